register_checker: RTL and testbench
===================================

# register_checker

Synthesizable self-checking monitor for the enable-load `register` block. It observes the register's `rst`, `en`, `in` and `out` pins and keeps its own reference model of the stored value. On every clock edge it compares the register's output against that model and reports check and error counts, plus the first failing values, so on-FPGA register instances can be verified without a simulator.

## Interface
- `WIDTH`, default 8: data width of the monitored register.
- `CNT_WIDTH`, default 16: width of the check and error counters.

- `clk`  in  1  clock shared with the monitored register.
- `rst`  in  1  checker reset. Asynchronous, active-low.
- `mon_rst`  in  1  monitored register's reset, active-high, sampled synchronously.
- `mon_en`  in  1  monitored register's load enable.
- `mon_in`  in  WIDTH  monitored register's data input.
- `mon_out`  in  WIDTH  monitored register's data output.
- `clear`  in  1  synchronous clear of results.
- `state`  out  2  checker state: 0 = UNSYNC, 1 = CHECK, 2 = HALT.
- `check_count`  out  CNT_WIDTH  number of comparisons performed, saturating.
- `error_count`  out  CNT_WIDTH  number of mismatches, saturating.
- `error`  out  1  sticky mismatch flag.
- `first_exp`  out  WIDTH  expected value at the first mismatch.
- `first_act`  out  WIDTH  `mon_out` value at the first mismatch.

## Operation
- **Model register `exp_q`** (internal). At each edge:
  - `mon_rst` = 1: load 0.
  - else `mon_en` = 1: load `mon_in`.
  - else hold.
- **State transitions**
  - UNSYNC → CHECK at the first edge where `mon_rst` = 1 or `mon_en` = 1. At that point the model value is defined.
  - No comparisons are made in UNSYNC.
- **Check.** At an edge where state = CHECK and `mon_rst` = 0, compare `mon_out` with the pre-edge `exp_q`.
  - `check_count` increments.
  - On mismatch, `error_count` increments and `error` is set.
  - If `error` was 0 before this edge, `first_exp`/`first_act` capture the pre-edge `exp_q` and `mon_out`.
- **`mon_rst` high while in CHECK.** Comparison is suppressed and the state stays CHECK.
- **Counters** saturate at all-ones and do not wrap. `error` stays set even when `error_count` is saturated.
- **`clear` = 1**
  - Zeroes both counters, `error`, `first_exp` and `first_act`.
  - State: HALT → UNSYNC; other states are unchanged.
  - `exp_q` is unaffected.
  - `clear` takes priority over a check on the same edge: that edge is neither counted nor flagged.

## Timing
- **Reset values** (on `rst` = 0):
  - `state` = UNSYNC, `exp_q` = 0.
  - All counters, `error`, `first_exp` and `first_act` = 0.
  - Reset takes effect immediately, including mid-run.
- **Latency.** All outputs are registered. A comparison sampled at edge k is visible on the outputs just after edge k: zero added cycles.
- **Sampling.** All `mon_*` inputs are sampled at the rising edge only. `mon_out` must be settled before the edge, i.e. it reflects the register's value from the previous edge.
- **Simultaneous events.** If a mismatch coincides with `check_count` saturation, the mismatch is still recorded.

## Configuration
- Macro: `REGISTER_CHECKER_HALT_EN`.
- **Defined:** the first mismatch moves CHECK → HALT at the same edge.
  - In HALT, counters, `error` and the `first_*` outputs freeze and no comparisons occur.
  - `exp_q` keeps tracking.
  - Leave HALT only via `clear` (→ UNSYNC) or `rst`.
- **Undefined:** HALT is unreachable. Checking continues after mismatches and `state` never reads 2.

## Test plan
- **Reset and sync.**
  - Stimulus: `rst` = 0 for 3 cycles, release, then 4 idle edges with `mon_rst` = 0 and `mon_en` = 0.
  - Required: `state` = 0 and `check_count` = 0 throughout. Then one edge with `mon_rst` = 1 → `state` = 1.
- **Correct register.**
  - Stimulus: connect a golden `register` model and drive 1000 random `mon_in`/`mon_en` after `mon_rst`.
  - Required: `check_count` = 1000, `error_count` = 0, `error` = 0.
- **Injected fault.**
  - Stimulus: `exp_q` = 0x5A, `mon_en` = 0, and force `mon_out` = 0x5B for one edge.
  - Required: `error_count` = 1, `first_exp` = 0x5A, `first_act` = 0x5B. A second fault with 0x00 leaves `first_*` unchanged and `error_count` = 2.
- **Saturation.**
  - Stimulus: `CNT_WIDTH` = 4 and 20 consecutive mismatches.
  - Required: `error_count` = 15 and `check_count` = 15 after 20 edges.
- **Clear priority and `mon_rst` mid-run.**
  - Stimulus: assert `clear` on the same edge as a mismatch.
  - Required: all results read 0 afterwards.
  - Stimulus: assert `mon_rst` for 2 edges while `mon_out` is wrong.
  - Required: `check_count` unchanged and no error.
- **Halt (with `REGISTER_CHECKER_HALT_EN`).**
  - Stimulus: a mismatch, then 10 further edges.
  - Required: `state` = 2, counts frozen at check = N+1 and error = 1.
  - Stimulus: then `clear`.
  - Required: `state` = 0, results zeroed. Without the macro, the same stimulus gives `state` = 1 and `check_count` keeps incrementing.

Source files
------------

// File: rtl/register_checker.sv
// register_checker: on-chip self-checking monitor for an enable-load register.
// It keeps a reference copy of the register value, compares the register's
// output against that copy on every edge, and reports saturating check/error
// counts and the first mismatching pair.
// Optional build macro: REGISTER_CHECKER_HALT_EN. When it is defined, the first
// mismatch freezes all results in HALT until clear or reset.
module register_checker #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mon_rst,
    input  logic                 mon_en,
    input  logic [WIDTH-1:0]     mon_in,
    input  logic [WIDTH-1:0]     mon_out,
    input  logic                 clear,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] check_count,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic                 error,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_act
);

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [CNT_WIDTH-1:0] check_count_q, check_count_d;
    logic [CNT_WIDTH-1:0] error_count_q, error_count_d;
    logic                 error_q, error_d;
    logic [WIDTH-1:0]     first_exp_q, first_exp_d;
    logic [WIDTH-1:0]     first_act_q, first_act_d;

    logic do_check;
    logic mismatch;

    // Reference model of the monitored register; it tracks in every state,
    // including HALT, so a later resync starts from the true value.
    always_comb begin
        exp_d = exp_q;
        if (mon_rst) begin
            exp_d = '0;
        end else if (mon_en) begin
            exp_d = mon_in;
        end
    end

    // A comparison happens only in CHECK, outside a monitored reset, and
    // never on an edge where clear is asserted (clear wins).
    always_comb begin
        do_check = (state_q == ST_CHECK) && !mon_rst && !clear;
        mismatch = do_check && (mon_out != exp_q);
    end

    // Checker state: sync on the first edge that defines the model value.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNSYNC: begin
                if (mon_rst || mon_en) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef REGISTER_CHECKER_HALT_EN
                if (mismatch) begin
                    state_d = ST_HALT;
                end
`endif
            end
            ST_HALT: begin
                if (clear) begin
                    state_d = ST_UNSYNC;
                end
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    // Result registers: clear zeroes them, otherwise each check updates the
    // saturating counters and the first mismatch is captured while error is 0.
    always_comb begin
        check_count_d = check_count_q;
        error_count_d = error_count_q;
        error_d       = error_q;
        first_exp_d   = first_exp_q;
        first_act_d   = first_act_q;
        if (clear) begin
            check_count_d = '0;
            error_count_d = '0;
            error_d       = 1'b0;
            first_exp_d   = '0;
            first_act_d   = '0;
        end else if (do_check) begin
            if (check_count_q != '1) begin
                check_count_d = check_count_q + CNT_ONE;
            end
            if (mismatch) begin
                if (error_count_q != '1) begin
                    error_count_d = error_count_q + CNT_ONE;
                end
                error_d = 1'b1;
                if (!error_q) begin
                    first_exp_d = exp_q;
                    first_act_d = mon_out;
                end
            end
        end
    end

    // All state flops with asynchronous active-low checker reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_UNSYNC;
            exp_q         <= '0;
            check_count_q <= '0;
            error_count_q <= '0;
            error_q       <= 1'b0;
            first_exp_q   <= '0;
            first_act_q   <= '0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            check_count_q <= check_count_d;
            error_count_q <= error_count_d;
            error_q       <= error_d;
            first_exp_q   <= first_exp_d;
            first_act_q   <= first_act_d;
        end
    end

    assign state       = state_q;
    assign check_count = check_count_q;
    assign error_count = error_count_q;
    assign error       = error_q;
    assign first_exp   = first_exp_q;
    assign first_act   = first_act_q;

endmodule

// File: tb/tb_register_checker.sv
// Directed bench for register_checker: a vector table for the basic checking
// sequence, then hand sequences for fault capture, clear priority, halt,
// a golden-register random run, counter saturation and mid-run reset.
module tb_register_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mon_rst = 1'b0;
    logic       mon_en = 1'b0;
    logic [7:0] mon_in = 8'h00;
    logic [7:0] mon_out_drv = 8'h00;
    logic       use_gold = 1'b0;
    logic [7:0] gold_q = 8'h00;
    logic [7:0] mon_out;
    logic       clear = 1'b0;

    logic [1:0]  state, state4;
    logic [15:0] check_count, error_count;
    logic [3:0]  check_count4, error_count4;
    logic        error, error4;
    logic [7:0]  first_exp, first_act, first_exp4, first_act4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

`ifdef REGISTER_CHECKER_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    always #5 clk = ~clk;

    // Golden enable-load register used for the random run.
    always @(posedge clk) begin
        if (mon_rst)     gold_q <= 8'h00;
        else if (mon_en) gold_q <= mon_in;
    end

    assign mon_out = use_gold ? gold_q : mon_out_drv;

    register_checker #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_en(mon_en),
        .mon_in(mon_in), .mon_out(mon_out), .clear(clear),
        .state(state), .check_count(check_count), .error_count(error_count),
        .error(error), .first_exp(first_exp), .first_act(first_act)
    );

    register_checker #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_en(mon_en),
        .mon_in(mon_in), .mon_out(mon_out), .clear(clear),
        .state(state4), .check_count(check_count4), .error_count(error_count4),
        .error(error4), .first_exp(first_exp4), .first_act(first_act4)
    );

    typedef struct {
        logic        r;
        logic        en;
        logic [7:0]  din;
        logic [7:0]  dout;
        logic [1:0]  st;
        int unsigned cc;
        int unsigned ec;
        logic        er;
        logic [7:0]  fe;
        logic [7:0]  fa;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input int unsigned cc,
                           input int unsigned ec, input logic er,
                           input logic [7:0] fe, input logic [7:0] fa);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".check_count"}, 32'(check_count), cc);
        chk({tag, ".error_count"}, 32'(error_count), ec);
        chk({tag, ".error"}, 32'(error), 32'(er));
        chk({tag, ".first_exp"}, 32'(first_exp), 32'(fe));
        chk({tag, ".first_act"}, 32'(first_act), 32'(fa));
    endtask

    initial begin
        // After sync via mon_rst: exp_q = 0, state CHECK, counts 0.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h33, 2'd1, 0, 0, 1'b0, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h5A, 8'h00, 2'd1, 1, 0, 1'b0, 8'h00, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 8'hFF, 8'h5A, 2'd1, 2, 0, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 8'h3C, 8'h5A, 2'd1, 3, 0, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h3C, 2'd1, 4, 0, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 8'hAA, 2'd1, 4, 0, 1'b0, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 8'h11, 2'd1, 4, 0, 1'b0, 8'h00, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 5, 0, 1'b0, 8'h00, 8'h00};
        tbl[8] = '{1'b0, 1'b1, 8'h5A, 8'h00, 2'd1, 6, 0, 1'b0, 8'h00, 8'h00};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 8'h5B, HALT ? 2'd2 : 2'd1, 7, 1, 1'b1, 8'h5A, 8'h5B};

        // Reset held for 3 cycles.
        #1;
        chk_all("reset", 2'd0, 0, 0, 1'b0, 8'h00, 8'h00);
        repeat (3) step();
        chk("reset_hold.state", 32'(state), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle.state", 32'(state), 32'd0);
            chk("idle.check_count", 32'(check_count), 32'd0);
        end
        mon_rst = 1'b1;
        step();
        chk("sync.state", 32'(state), 32'd1);
        chk("sync.check_count", 32'(check_count), 32'd0);

        // Table-driven checking sequence ending in the first injected fault.
        for (int i = 0; i < 10; i++) begin
            mon_rst = tbl[i].r;
            mon_en = tbl[i].en;
            mon_in = tbl[i].din;
            mon_out_drv = tbl[i].dout;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].cc, tbl[i].ec,
                    tbl[i].er, tbl[i].fe, tbl[i].fa);
        end

        // Second fault: first_* must not move.
        mon_en = 1'b0;
        mon_out_drv = 8'h00;
        step();
        if (HALT) chk_all("fault2", 2'd2, 7, 1, 1'b1, 8'h5A, 8'h5B);
        else      chk_all("fault2", 2'd1, 8, 2, 1'b1, 8'h5A, 8'h5B);

        // Clear coinciding with a mismatch: nothing counted, all zeroed.
        clear = 1'b1;
        mon_out_drv = 8'h77;
        step();
        clear = 1'b0;
        chk_all("clear_prio", HALT ? 2'd0 : 2'd1, 0, 0, 1'b0, 8'h00, 8'h00);

        // Halt sequence: resync, 3 good checks, a mismatch, 10 more edges.
        mon_rst = 1'b1;
        step();
        mon_rst = 1'b0;
        chk("halt_sync.state", 32'(state), 32'd1);
        mon_out_drv = 8'h00;
        repeat (3) step();
        mon_out_drv = 8'h01;
        step();
        mon_out_drv = 8'h00;
        repeat (10) step();
        if (HALT) chk_all("halt", 2'd2, 4, 1, 1'b1, 8'h00, 8'h01);
        else      chk_all("halt", 2'd1, 14, 1, 1'b1, 8'h00, 8'h01);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_all("halt_clear", HALT ? 2'd0 : 2'd1, 0, 0, 1'b0, 8'h00, 8'h00);

        // Golden register run: 1000 random loads/holds, no errors expected.
        mon_rst = 1'b1;
        step();
        mon_rst = 1'b0;
        use_gold = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            mon_en = 1'($urandom_range(0, 1));
            mon_in = 8'($urandom);
            step();
        end
        use_gold = 1'b0;
        mon_en = 1'b0;
        chk("gold.state", 32'(state), 32'd1);
        chk("gold.check_count", 32'(check_count), 32'd1000);
        chk("gold.error_count", 32'(error_count), 32'd0);
        chk("gold.error", 32'(error), 32'd0);

        // Saturation on the 4-bit-counter instance: 20 consecutive mismatches.
        clear = 1'b1;
        mon_rst = 1'b1;
        step();
        clear = 1'b0;
        mon_rst = 1'b0;
        chk("sat_clear.check_count4", 32'(check_count4), 32'd0);
        mon_out_drv = 8'hFF;
        repeat (14) step();
        if (!HALT) begin
            chk("sat14.check_count4", 32'(check_count4), 32'd14);
            chk("sat14.error_count4", 32'(error_count4), 32'd14);
        end
        repeat (6) step();
        chk("sat.check_count4", 32'(check_count4), HALT ? 32'd1 : 32'd15);
        chk("sat.error_count4", 32'(error_count4), HALT ? 32'd1 : 32'd15);
        chk("sat.error4", 32'(error4), 32'd1);
        chk("sat.first_act4", 32'(first_act4), 32'hFF);
        chk("sat.first_exp4", 32'(first_exp4), 32'h00);
        chk("sat.check_count", 32'(check_count), HALT ? 32'd1 : 32'd20);

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 0, 0, 1'b0, 8'h00, 8'h00);
        chk("async_rst.error_count4", 32'(error_count4), 32'd0);
        chk("async_rst.state4", 32'(state4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
